axis_pkt_gen: RTL
=================

Name: axis_pkt_gen

Overview:
AXI-Stream packet source that drives the slave (s_axis) side of the team's stream FIFOs and datapaths. When started, it emits a configured number of packets of a configured length. Data is a deterministic incrementing pattern, so a downstream sink can check it. Used as the transmit end in unit benches and as a built-in traffic source for bring-up.

Parameters:
P_DATA_WIDTH, 16, width of m_axis_tdata and of the data pattern counter
P_LEN_WIDTH, 16, width of cfg_pkt_len and of the internal beat counter
P_CNT_WIDTH, 16, width of cfg_num_pkts and of pkt_count

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-low
start  input  1  single-cycle request; sampled only in IDLE
stop  input  1  request to end after the current packet completes
cfg_pkt_len  input  P_LEN_WIDTH  beats per packet; 0 is treated as 1
cfg_num_pkts  input  P_CNT_WIDTH  packets to send; 0 means continuous until stop
cfg_seed  input  P_DATA_WIDTH  tdata value of the first beat
cfg_gap  input  8  idle cycles between packets (used only with the optional feature)
m_axis_tvalid  output  1  stream valid
m_axis_tready  input  1  stream ready
m_axis_tdata  output  P_DATA_WIDTH  stream data
m_axis_tlast  output  1  high on the last beat of each packet
busy  output  1  high whenever not in IDLE
done  output  1  one-cycle pulse when the final packet completes
pkt_count  output  P_CNT_WIDTH  packets fully accepted since the last start

Behaviour:
- Clock is clk. Reset is rst_n: synchronous, active-low.
- Reset (rst_n=0 at an edge):
  - state=IDLE.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
  - busy=0, done=0, pkt_count=0.
  - Internal counters cleared.
  - Reset mid-packet drops tvalid on the next edge; the partial packet is abandoned with no tlast.
- Beat acceptance: beat = m_axis_tvalid & m_axis_tready at a rising edge.
- Outputs are registered; no combinational path from m_axis_tready to any output.
- AXIS rules:
  - While tvalid=1 and tready=0, tdata and tlast hold stable.
  - tvalid never drops without a beat, except on reset.
- State IDLE:
  - start=1 latches cfg_pkt_len (0→1), cfg_num_pkts and cfg_seed.
  - Clears pkt_count; moves to SEND.
  - tvalid=1 from the next cycle, tdata=cfg_seed.
  - start while busy is ignored; stop in IDLE has no effect.
- State SEND:
  - Each beat: tdata increments by 1, modulo 2^P_DATA_WIDTH (wraps silently); the beat counter increments.
  - tlast=1 exactly on beat index len-1. A 1-beat packet has tlast on its only beat.
  - On a tlast beat, pkt_count increments.
  - Go to IDLE if any of the following holds; tvalid=0 on the next cycle and done pulses that cycle:
    - pkt_count+1 == num_pkts with num_pkts≠0;
    - stop was seen (sticky) at any time during the packet.
  - Otherwise continue: the next packet's first beat follows with no bubble. tdata continues incrementing across packets and is not reloaded from the seed.
- pkt_count saturates at all-ones in continuous mode; it does not wrap.
- stop together with start in IDLE: start wins, and stop is not latched.
- Latency: start edge → first tvalid = 1 cycle; final beat → done pulse = 1 cycle.

Optional Feature:
AXIS_PKT_GEN_GAP_EN
- Defined:
  - Adds a GAP state after every tlast beat that is not the final one.
  - GAP holds tvalid=0 for cfg_gap cycles, with cfg_gap latched at start. cfg_gap=0 skips GAP entirely.
  - stop seen during GAP goes to IDLE with done, without starting another packet.
- Undefined:
  - No GAP state; cfg_gap is unused; packets are always back-to-back.

Decomposition:
- Shared package axis_pkg:
  - state enum typedef (IDLE, SEND, GAP);
  - localparam for the cfg_gap width (8);
  - AXIS beat struct typedef (data, last) for reuse with the FIFO benches.
- One natural sub-module: axis_pkt_gen_ctr, a loadable, enabled beat/packet counter with a terminal-count flag. It is instantiated for the beat index and the packet index.

Test Plan:
- len=4, num=2, seed=0x00FE, tready=1 → 8 beats, tdata FE,FF,100,101,102,103,104,105; tlast on beats 4 and 8; done pulses 1 cycle after beat 8; pkt_count=2.
- Same config, tready toggling 1010… → tdata/tlast stable across every stall; identical beat sequence; no tvalid drop mid-packet.
- P_DATA_WIDTH=8, seed=0xFE, len=3, num=1 → tdata FE,FF,00 with tlast on 00 (wrap check).
- len=0, num=3 → three 1-beat packets, tlast=1 on every beat, pkt_count=3.
- num=0 (continuous), len=5, stop asserted on beat 7 → packet 2 completes (beat 10 tlast), then IDLE, done pulse, pkt_count=2.
- rst_n low during beat 2 of a len=4 packet → next cycle tvalid=0, busy=0, pkt_count=0; new start restarts at seed. With AXIS_PKT_GEN_GAP_EN and cfg_gap=3, exactly 3 idle cycles occur between tlast and the next first beat.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared AXI-Stream types: generator FSM states, gap width and beat bundle.
package axis_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_e;

  localparam int GAP_W   = 8;
  localparam int AXIS_DW = 16;

  typedef struct packed {
    logic [AXIS_DW-1:0] data;
    logic               last;
  } axis_beat_t;

endpackage

// File: rtl/axis_pkt_gen_ctr.sv
// Loadable, enabled, saturating counter with a terminal-count compare.
module axis_pkt_gen_ctr #(
  parameter int P_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ld_i,
  input  logic [P_W-1:0] ld_val_i,
  input  logic           en_i,
  input  logic [P_W-1:0] term_i,
  output logic [P_W-1:0] cnt_o,
  output logic           tc_o
);

  logic [P_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (ld_i) begin
      cnt_q <= ld_val_i;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == term_i);

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI-Stream incrementing-pattern packet source.
// Define AXIS_PKT_GEN_GAP_EN to insert cfg_gap idle cycles between packets.
module axis_pkt_gen
  import axis_pkg::*;
#(
  parameter int P_DATA_WIDTH = 16,
  parameter int P_LEN_WIDTH  = 16,
  parameter int P_CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic [P_LEN_WIDTH-1:0]  cfg_pkt_len,
  input  logic [P_CNT_WIDTH-1:0]  cfg_num_pkts,
  input  logic [P_DATA_WIDTH-1:0] cfg_seed,
  input  logic [GAP_W-1:0]        cfg_gap,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [P_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic                    busy,
  output logic                    done,
  output logic [P_CNT_WIDTH-1:0]  pkt_count
);

  state_e                  state_q;
  logic [P_LEN_WIDTH-1:0]  len_q;
  logic [P_CNT_WIDTH-1:0]  num_q;
  logic [P_DATA_WIDTH-1:0] data_q;
  logic                    valid_q;
  logic                    last_q;
  logic                    done_q;
  logic                    stop_q;
`ifdef AXIS_PKT_GEN_GAP_EN
  logic [GAP_W-1:0]        gap_q;
  logic [GAP_W-1:0]        gap_cnt_q;
`else
  logic                    unused_gap;
  assign unused_gap = ^cfg_gap;
`endif

  logic                   beat;
  logic                   start_go;
  logic                   pkt_end;
  logic                   final_pkt;
  logic                   stop_seen;
  logic                   beat_tc;
  logic                   pkt_tc;
  logic [P_LEN_WIDTH-1:0] len_in;
  logic [P_LEN_WIDTH-1:0] beat_idx;

  assign beat      = valid_q & m_axis_tready;
  assign start_go  = (state_q == IDLE) & start;
  assign pkt_end   = beat & last_q;
  assign final_pkt = pkt_tc & (num_q != '0);
  assign stop_seen = stop_q | stop;
  assign len_in    = (cfg_pkt_len == '0) ? P_LEN_WIDTH'(1)
                                         : cfg_pkt_len;

  // beat_tc flags the second-to-last beat, so tlast can be registered
  axis_pkt_gen_ctr #(.P_W(P_LEN_WIDTH)) u_beat_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_i     (start_go | pkt_end),
    .ld_val_i ('0),
    .en_i     (beat),
    .term_i   (len_q - P_LEN_WIDTH'(2)),
    .cnt_o    (beat_idx),
    .tc_o     (beat_tc)
  );

  axis_pkt_gen_ctr #(.P_W(P_CNT_WIDTH)) u_pkt_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_i     (start_go),
    .ld_val_i ('0),
    .en_i     (pkt_end),
    .term_i   (num_q - P_CNT_WIDTH'(1)),
    .cnt_o    (pkt_count),
    .tc_o     (pkt_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      len_q     <= '0;
      num_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      stop_q    <= 1'b0;
`ifdef AXIS_PKT_GEN_GAP_EN
      gap_q     <= '0;
      gap_cnt_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            len_q   <= len_in;
            num_q   <= cfg_num_pkts;
            data_q  <= cfg_seed;
            valid_q <= 1'b1;
            last_q  <= (len_in == P_LEN_WIDTH'(1));
            stop_q  <= 1'b0;
`ifdef AXIS_PKT_GEN_GAP_EN
            gap_q   <= cfg_gap;
`endif
            state_q <= SEND;
          end
        end
        SEND: begin
          stop_q <= stop_seen;
          if (beat) begin
            data_q <= data_q + 1'b1;
            if (last_q) begin
              if (final_pkt || stop_seen) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= IDLE;
              end else begin
                stop_q <= 1'b0;
                last_q <= (len_q == P_LEN_WIDTH'(1));
`ifdef AXIS_PKT_GEN_GAP_EN
                if (gap_q != '0) begin
                  valid_q   <= 1'b0;
                  gap_cnt_q <= gap_q - 1'b1;
                  state_q   <= GAP;
                end
`endif
              end
            end else begin
              last_q <= beat_tc;
            end
          end
        end
`ifdef AXIS_PKT_GEN_GAP_EN
        GAP: begin
          if (stop) begin
            last_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else if (gap_cnt_q == '0) begin
            valid_q <= 1'b1;
            state_q <= SEND;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  logic unused_idx;
  assign unused_idx = ^beat_idx;

  assign m_axis_tvalid = valid_q;
  assign m_axis_tdata  = data_q;
  assign m_axis_tlast  = last_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;

endmodule
